// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mips_pkg
//  Description : Shared types and constants for the MIPS pipeline control
//                path. ctrl_t is the decoder control bundle carried from
//                Decode through the Execute, Memory and Writeback stages.
//  Revision    : 1.0  initial release
// ============================================================================
package mips_pkg;

    // Decoder control bundle, MSB first.
    typedef struct packed {
        logic       regwrite;
        logic       memtoreg;
        logic       memwrite;
        logic       alusrc;
        logic       regdst;
        logic       branch;
        logic [2:0] alucontrol;
    } ctrl_t;

    localparam int CTRL_W = $bits(ctrl_t);

    // Bubble control: no register-file write, no memory write, ALU op 000.
    localparam ctrl_t CTRL_BUBBLE = '0;

    // Build a control bundle from the individual decoder outputs.
    function automatic ctrl_t ctrl_pack(
        input logic       regwrite,
        input logic       memtoreg,
        input logic       memwrite,
        input logic       alusrc,
        input logic       regdst,
        input logic       branch,
        input logic [2:0] alucontrol
    );
        ctrl_t c;
        c.regwrite   = regwrite;
        c.memtoreg   = memtoreg;
        c.memwrite   = memwrite;
        c.alusrc     = alusrc;
        c.regdst     = regdst;
        c.branch     = branch;
        c.alucontrol = alucontrol;
        return c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ctrl_stage_reg.sv
`default_nettype none
// ============================================================================
//  Module      : ctrl_stage_reg
//  Description : One pipeline stage register holding {valid, ctrl_t}.
//                Asynchronous active-low reset and a synchronous kill that
//                loads a bubble (valid=0, all controls zero).
//  Ports       : clk      - clock, rising edge
//                rst_n    - asynchronous reset, active low
//                i_kill   - load a bubble at this edge (wins over i_valid)
//                i_valid  - incoming occupancy
//                i_ctrl   - incoming control bundle
//                o_valid  - registered occupancy
//                o_ctrl   - registered control bundle
//  Revision    : 1.0  initial release
// ============================================================================
module ctrl_stage_reg
    import mips_pkg::*;
(
    input  logic  clk,
    input  logic  rst_n,
    input  logic  i_kill,
    input  logic  i_valid,
    input  ctrl_t i_ctrl,
    output logic  o_valid,
    output ctrl_t o_ctrl
);

    logic  r_valid;
    ctrl_t r_ctrl;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_ctrl  <= CTRL_BUBBLE;
        end else if (i_kill) begin
            r_valid <= 1'b0;
            r_ctrl  <= CTRL_BUBBLE;
        end else begin
            r_valid <= i_valid;
            r_ctrl  <= i_ctrl;
        end
    end

    assign o_valid = r_valid;
    assign o_ctrl  = r_ctrl;

endmodule
`default_nettype wire

// File: rtl/ctrl_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : ctrl_pipe
//  Description : Control-signal pipeline of the pipelined MIPS core. Carries
//                the Decode control bundle through the E, M and W stage
//                registers, squashes wrong-path work on a taken branch,
//                honours the hazard unit's Execute flush, derives PCSrcM and
//                counts retired instructions and Writeback bubbles.
//  Ports       : clk, reset (async, active low)
//                ValidD, *D           - Decode-stage instruction and controls
//                FlushE               - insert a bubble into E at this edge
//                ZeroE                - ALU zero flag of the E instruction
//                *E / *M / *W         - registered stage controls
//                ValidE/M/W           - stage occupancy
//                PCSrcM               - branch taken (from M state only)
//                RetiredCnt/BubbleCnt - free-running wrapping counters
//  Revision    : 1.0  initial release
// ============================================================================
module ctrl_pipe
    import mips_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ValidD,
    input  logic             RegWriteD,
    input  logic             MemtoRegD,
    input  logic             MemWriteD,
    input  logic             ALUSrcD,
    input  logic             RegDstD,
    input  logic             BranchD,
    input  logic [2:0]       ALUControlD,
    input  logic             FlushE,
    input  logic             ZeroE,
    output logic             RegWriteE,
    output logic             MemtoRegE,
    output logic             ALUSrcE,
    output logic             RegDstE,
    output logic [2:0]       ALUControlE,
    output logic             MemtoRegM,
    output logic             MemWriteM,
    output logic             RegWriteM,
    output logic             PCSrcM,
    output logic             RegWriteW,
    output logic             MemtoRegW,
    output logic             ValidE,
    output logic             ValidM,
    output logic             ValidW,
    output logic [CNT_W-1:0] RetiredCnt,
    output logic [CNT_W-1:0] BubbleCnt
);

    localparam logic [CNT_W-1:0] c_cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};

    ctrl_t            w_d_ctrl;
    logic             w_kill_e;
    logic             w_kill_m;
    logic             w_e_valid;
    ctrl_t            w_e_ctrl;
    logic             w_m_valid;
    ctrl_t            w_m_ctrl;
    logic             w_w_valid;
    ctrl_t            w_w_ctrl;
    logic             r_zero_m;
    logic             w_pcsrc;
    logic [CNT_W-1:0] r_retired;
    logic [CNT_W-1:0] r_bubble;

    assign w_d_ctrl = ctrl_pack(RegWriteD, MemtoRegD, MemWriteD, ALUSrcD,
                                RegDstD, BranchD, ALUControlD);

    // Taken branch is decided purely from M-stage state so PCSrcM has no
    // combinational path from any input port.
    assign w_pcsrc = w_m_valid & w_m_ctrl.branch & r_zero_m;

    // E is a bubble on a taken branch (wrong path), a hazard flush, or a
    // fetch bubble in Decode. Coincident taken branch and flush still give
    // exactly one bubble.
    assign w_kill_e = w_pcsrc | FlushE | ~ValidD;

    // The instruction in E is wrong-path when the branch in M is taken.
    assign w_kill_m = w_pcsrc;

    ctrl_stage_reg u_stage_e (
        .clk     (clk),
        .rst_n   (reset),
        .i_kill  (w_kill_e),
        .i_valid (ValidD),
        .i_ctrl  (w_d_ctrl),
        .o_valid (w_e_valid),
        .o_ctrl  (w_e_ctrl)
    );

    ctrl_stage_reg u_stage_m (
        .clk     (clk),
        .rst_n   (reset),
        .i_kill  (w_kill_m),
        .i_valid (w_e_valid),
        .i_ctrl  (w_e_ctrl),
        .o_valid (w_m_valid),
        .o_ctrl  (w_m_ctrl)
    );

    // The taken branch itself always proceeds to W and retires.
    ctrl_stage_reg u_stage_w (
        .clk     (clk),
        .rst_n   (reset),
        .i_kill  (1'b0),
        .i_valid (w_m_valid),
        .i_ctrl  (w_m_ctrl),
        .o_valid (w_w_valid),
        .o_ctrl  (w_w_ctrl)
    );

    // Zero flag travels alongside the M register and shares its squash.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_zero_m <= 1'b0;
        end else if (w_kill_m) begin
            r_zero_m <= 1'b0;
        end else begin
            r_zero_m <= ZeroE;
        end
    end

    // Counters look at the W contents present before each edge; both wrap.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_retired <= '0;
            r_bubble  <= '0;
        end else if (w_w_valid) begin
            r_retired <= r_retired + c_cnt_one;
        end else begin
            r_bubble  <= r_bubble + c_cnt_one;
        end
    end

    // W carries the full bundle but only two controls leave the block.
    logic w_unused_w;
    assign w_unused_w = ^{w_w_ctrl.memwrite, w_w_ctrl.alusrc, w_w_ctrl.regdst,
                          w_w_ctrl.branch, w_w_ctrl.alucontrol};

    assign RegWriteE   = w_e_ctrl.regwrite;
    assign MemtoRegE   = w_e_ctrl.memtoreg;
    assign ALUSrcE     = w_e_ctrl.alusrc;
    assign RegDstE     = w_e_ctrl.regdst;
    assign ALUControlE = w_e_ctrl.alucontrol;
    assign ValidE      = w_e_valid;

    assign MemtoRegM   = w_m_ctrl.memtoreg;
    assign MemWriteM   = w_m_ctrl.memwrite;
    assign RegWriteM   = w_m_ctrl.regwrite;
    assign ValidM      = w_m_valid;
    assign PCSrcM      = w_pcsrc;

    assign RegWriteW   = w_w_ctrl.regwrite;
    assign MemtoRegW   = w_w_ctrl.memtoreg;
    assign ValidW      = w_w_valid;

    assign RetiredCnt  = r_retired;
    assign BubbleCnt   = r_bubble;

endmodule
`default_nettype wire

// File: tb/tb_ctrl_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ctrl_pipe
//  Description : Scoreboard bench for ctrl_pipe. A driver issues stimulus and
//                pushes the expected post-edge outputs computed by a
//                behavioural instruction-slot model; a monitor on the falling
//                edge pops and compares. A second instance with CNT_W=4
//                exercises counter wrap.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_ctrl_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset = 1'b0;
    logic       ValidD = 1'b0, RegWriteD = 1'b0, MemtoRegD = 1'b0, MemWriteD = 1'b0;
    logic       ALUSrcD = 1'b0, RegDstD = 1'b0, BranchD = 1'b0;
    logic [2:0] ALUControlD = 3'b000;
    logic       FlushE = 1'b0, ZeroE = 1'b0;

    logic        RegWriteE, MemtoRegE, ALUSrcE, RegDstE, MemtoRegM, MemWriteM, RegWriteM;
    logic        PCSrcM, RegWriteW, MemtoRegW, ValidE, ValidM, ValidW;
    logic [2:0]  ALUControlE;
    logic [31:0] RetiredCnt, BubbleCnt;

    logic        RegWriteE4, MemtoRegE4, ALUSrcE4, RegDstE4, MemtoRegM4, MemWriteM4, RegWriteM4;
    logic        PCSrcM4, RegWriteW4, MemtoRegW4, ValidE4, ValidM4, ValidW4;
    logic [2:0]  ALUControlE4;
    logic [3:0]  RetiredCnt4, BubbleCnt4;

    ctrl_pipe dut (
        .clk(clk), .reset(reset), .ValidD(ValidD), .RegWriteD(RegWriteD),
        .MemtoRegD(MemtoRegD), .MemWriteD(MemWriteD), .ALUSrcD(ALUSrcD),
        .RegDstD(RegDstD), .BranchD(BranchD), .ALUControlD(ALUControlD),
        .FlushE(FlushE), .ZeroE(ZeroE), .RegWriteE(RegWriteE), .MemtoRegE(MemtoRegE),
        .ALUSrcE(ALUSrcE), .RegDstE(RegDstE), .ALUControlE(ALUControlE),
        .MemtoRegM(MemtoRegM), .MemWriteM(MemWriteM), .RegWriteM(RegWriteM),
        .PCSrcM(PCSrcM), .RegWriteW(RegWriteW), .MemtoRegW(MemtoRegW),
        .ValidE(ValidE), .ValidM(ValidM), .ValidW(ValidW),
        .RetiredCnt(RetiredCnt), .BubbleCnt(BubbleCnt)
    );

    ctrl_pipe #(.CNT_W(4)) dut4 (
        .clk(clk), .reset(reset), .ValidD(ValidD), .RegWriteD(RegWriteD),
        .MemtoRegD(MemtoRegD), .MemWriteD(MemWriteD), .ALUSrcD(ALUSrcD),
        .RegDstD(RegDstD), .BranchD(BranchD), .ALUControlD(ALUControlD),
        .FlushE(FlushE), .ZeroE(ZeroE), .RegWriteE(RegWriteE4), .MemtoRegE(MemtoRegE4),
        .ALUSrcE(ALUSrcE4), .RegDstE(RegDstE4), .ALUControlE(ALUControlE4),
        .MemtoRegM(MemtoRegM4), .MemWriteM(MemWriteM4), .RegWriteM(RegWriteM4),
        .PCSrcM(PCSrcM4), .RegWriteW(RegWriteW4), .MemtoRegW(MemtoRegW4),
        .ValidE(ValidE4), .ValidM(ValidM4), .ValidW(ValidW4),
        .RetiredCnt(RetiredCnt4), .BubbleCnt(BubbleCnt4)
    );

    // Control encodings {regwrite, memtoreg, memwrite, alusrc, regdst, branch, alu[2:0]}
    localparam logic [8:0] C_ADD = 9'b1_0_0_0_1_0_010;
    localparam logic [8:0] C_LW  = 9'b1_1_0_1_0_0_010;
    localparam logic [8:0] C_SW  = 9'b0_0_1_1_0_0_010;
    localparam logic [8:0] C_BEQ = 9'b0_0_0_0_0_1_110;

    // Reference model: one slot per stage, each an instruction or a bubble.
    typedef struct packed {
        logic       valid;
        logic       rw, m2r, mw, als, rd, br;
        logic [2:0] alu;
        logic       z;
    } slot_t;

    typedef struct packed {
        logic [15:0] ctl;
        logic [31:0] ret;
        logic [31:0] bub;
    } exp_t;

    slot_t       mE, mM, mW;
    int unsigned mRet, mBub;
    exp_t        sb[$];
    int          total = 0;
    int          bad   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    function automatic logic [15:0] obs();
        return {RegWriteE, MemtoRegE, ALUSrcE, RegDstE, ALUControlE, ValidE,
                MemtoRegM, MemWriteM, RegWriteM, ValidM, PCSrcM,
                RegWriteW, MemtoRegW, ValidW};
    endfunction

    function automatic logic [15:0] obs4();
        return {RegWriteE4, MemtoRegE4, ALUSrcE4, RegDstE4, ALUControlE4, ValidE4,
                MemtoRegM4, MemWriteM4, RegWriteM4, ValidM4, PCSrcM4,
                RegWriteW4, MemtoRegW4, ValidW4};
    endfunction

    function automatic exp_t model_exp();
        exp_t e;
        e.ctl = {mE.rw, mE.m2r, mE.als, mE.rd, mE.alu, mE.valid,
                 mM.m2r, mM.mw, mM.rw, mM.valid, (mM.valid & mM.br & mM.z),
                 mW.rw, mW.m2r, mW.valid};
        e.ret = mRet;
        e.bub = mBub;
        return e;
    endfunction

    task automatic model_reset();
        mE = '0; mM = '0; mW = '0;
        mRet = 0; mBub = 0;
    endtask

    // Drive D-side inputs for the coming edge and record what that edge yields.
    task automatic apply(input logic v, input logic [8:0] c, input logic fl, input logic z);
        logic taken;
        ValidD = v;
        {RegWriteD, MemtoRegD, MemWriteD, ALUSrcD, RegDstD, BranchD, ALUControlD} = c;
        FlushE = fl;
        ZeroE  = z;
        taken = mM.valid & mM.br & mM.z;
        if (mW.valid) mRet++; else mBub++;
        mW = mM;
        if (taken) mM = '0;
        else begin
            mM   = mE;
            mM.z = z;
        end
        if (taken || fl || !v) mE = '0;
        else mE = {1'b1, c, 1'b0};
        sb.push_back(model_exp());
    endtask

    task automatic step(input logic v, input logic [8:0] c, input logic fl, input logic z);
        @(negedge clk);
        #1;
        apply(v, c, fl, z);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 9'h000, 1'b0, 1'b0);
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_ctl"}, {48'h0, obs()}, 64'h0);
        chk({tag, "_ctl4"}, {48'h0, obs4()}, 64'h0);
        chk({tag, "_ret"}, {32'h0, RetiredCnt}, 64'h0);
        chk({tag, "_bub"}, {32'h0, BubbleCnt}, 64'h0);
        chk({tag, "_cnt4"}, {56'h0, RetiredCnt4, BubbleCnt4}, 64'h0);
    endtask

    // Monitor: one expected entry per rising edge, compared mid-cycle.
    always @(negedge clk) begin
        exp_t e;
        if (reset && sb.size() > 0) begin
            e = sb.pop_front();
            chk("ctl", {48'h0, obs()}, {48'h0, e.ctl});
            chk("ctl4", {48'h0, obs4()}, {48'h0, e.ctl});
            chk("retired", {32'h0, RetiredCnt}, {32'h0, e.ret});
            chk("bubble", {32'h0, BubbleCnt}, {32'h0, e.bub});
            chk("cnt4", {56'h0, RetiredCnt4, BubbleCnt4}, {56'h0, e.ret[3:0], e.bub[3:0]});
        end
    end

    initial begin
        #400000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        model_reset();
        @(negedge clk);
        #1;
        check_reset_state("reset");
        reset = 1'b1;

        // Four R-type instructions back to back, then drain.
        apply(1'b1, C_ADD, 1'b0, 1'b0);
        repeat (3) step(1'b1, C_ADD, 1'b0, 1'b0);
        idle(5);

        // Load-use: flush with lw held in D, then lw proceeds.
        step(1'b1, C_LW, 1'b1, 1'b0);
        step(1'b1, C_LW, 1'b0, 1'b0);
        idle(4);

        // Taken beq followed by two sw that must be squashed.
        step(1'b1, C_BEQ, 1'b0, 1'b0);
        step(1'b1, C_SW, 1'b0, 1'b1);
        step(1'b1, C_SW, 1'b0, 1'b0);
        idle(4);

        // Untaken beq: the following sw writes memory.
        step(1'b1, C_BEQ, 1'b0, 1'b0);
        step(1'b1, C_SW, 1'b0, 1'b0);
        step(1'b1, C_ADD, 1'b0, 1'b0);
        idle(4);

        // Flush coincident with a taken branch in M.
        step(1'b1, C_BEQ, 1'b0, 1'b0);
        step(1'b1, C_ADD, 1'b0, 1'b1);
        step(1'b1, C_LW, 1'b1, 1'b0);
        step(1'b1, C_SW, 1'b0, 1'b0);
        idle(4);

        // Asynchronous reset mid-cycle with three instructions in flight.
        repeat (3) step(1'b1, C_ADD, 1'b0, 1'b0);
        @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        check_reset_state("async_rst");
        sb.delete();
        model_reset();
        @(negedge clk);
        #1;
        reset = 1'b1;
        apply(1'b0, 9'h000, 1'b0, 1'b0);

        // Enough valid instructions to wrap the 4-bit retired counter.
        repeat (20) step(1'b1, C_ADD, 1'b0, 1'b0);
        idle(4);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            logic       v, fl, z;
            logic [8:0] c;
            v  = ($urandom_range(0, 3) != 0);
            fl = ($urandom_range(0, 6) == 0);
            z  = $urandom_range(0, 1) == 1;
            c  = 9'($urandom);
            if ($urandom_range(0, 2) == 0) c[3] = 1'b1;
            step(v, c, fl, z);
        end
        idle(4);

        @(negedge clk);
        #1;
        chk("sb_drained", 64'(sb.size()), 64'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
